// File: rtl/sha_unpad.sv
// sha_unpad: strips SHA-style padding from a block stream and emits the message as 32-bit words.
// Define SHA_UNPAD_CHECK_EN to also verify the 0x80/zero padding bytes.
module sha_unpad #(
  parameter int Nlen = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [511:0]    block_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic            accept_o,
  output logic [31:0]     word_o,
  output logic [2:0]      keep_o,
  output logic            word_valid_o,
  input  logic            word_ready_i,
  output logic            done_o,
  output logic [Nlen-1:0] length_o,
  output logic            error_o
);
  localparam int EW = Nlen - 3;
  typedef enum logic [2:0] {IDLE, HOLD, DRAIN, CHECK, FINAL, DONE} state_t;
  state_t          state_q, state_d;
  logic [511:0]    p_q, p_d, c_q, c_d;
  logic            p_held_q, p_held_d;
  logic [EW-1:0]   e_q, e_d;
  logic [Nlen-1:0] len_q, len_d;
  logic            err_q, err_d;
  logic [31:0]     word_q, word_d;
  logic [2:0]      keep_q, keep_d;
  logic            wv_q, wv_d;
  logic [4:0]      idx_q, idx_d;
  logic [6:0]      r_q, r_d;
  logic [1023:0]   s;
  logic [EW-1:0]   r;
  logic            len_err, pad_err, free, last_w;
  logic [4:0]      n;
  logic [2:0]      keep_n;
  logic [31:0]     mask;
  // Byte stream seen by CHECK/FINAL: P followed by C when P is held, otherwise C alone.
  assign s       = p_held_q ? {c_q, p_q} : {512'b0, c_q};
  assign r       = len_q[Nlen-1:3] - e_q;
  assign len_err = |len_q[2:0] | (p_held_q ? (r < EW'(56) || r > EW'(119)) : r > EW'(55));
`ifdef SHA_UNPAD_CHECK_EN
  always_comb begin
    pad_err = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (7'(k) == r[6:0] && s[(k/4)*32 + 24 - 8*(k%4) +: 8] != 8'h80) pad_err = 1'b1;
      if (7'(k) > r[6:0] && 7'(k) <= (p_held_q ? 7'd119 : 7'd55) && s[(k/4)*32 + 24 - 8*(k%4) +: 8] != 8'h00) pad_err = 1'b1;
    end
  end
`else
  assign pad_err = 1'b0;
`endif
  assign n        = state_q == DRAIN ? 5'd16 : 5'((r_q + 7'd3) >> 2);
  assign last_w   = state_q == FINAL && idx_q == n - 5'd1;
  assign keep_n   = last_w && r_q[1:0] != 2'd0 ? {1'b0, r_q[1:0]} : 3'd4;
  assign mask     = ~(32'hffffffff >> {keep_n, 3'b000});
  assign free     = !wv_q || word_ready_i;
  assign accept_o     = state_q == IDLE || state_q == HOLD;
  assign done_o       = state_q == DONE;
  assign word_o       = word_q;
  assign keep_o       = keep_q;
  assign word_valid_o = wv_q;
  assign length_o     = len_q;
  assign error_o      = err_q;
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    c_d      = c_q;
    p_held_d = p_held_q;
    e_d      = e_q;
    len_d    = len_q;
    err_d    = err_q;
    word_d   = word_q;
    keep_d   = keep_q;
    wv_d     = wv_q;
    idx_d    = idx_q;
    r_d      = r_q;
    if (accept_o && valid_i) begin
      if (last_i) begin
        c_d     = block_i;
        len_d   = {block_i[479:448], block_i[511:480]};
        err_d   = 1'b0;
        state_d = CHECK;
      end else if (state_q == IDLE) begin
        p_d      = block_i;
        p_held_d = 1'b1;
        state_d  = HOLD;
      end else begin
        c_d     = block_i;
        idx_d   = 5'd0;
        state_d = DRAIN;
      end
    end
    if (state_q == CHECK) begin
      err_d   = len_err | pad_err;
      r_d     = r[6:0];
      idx_d   = 5'd0;
      state_d = len_err | pad_err ? DONE : FINAL;
    end
    // Output slot is free when empty or being consumed this cycle.
    if ((state_q == DRAIN || state_q == FINAL) && free) begin
      if (idx_q < n) begin
        word_d = s[{idx_q, 5'b0} +: 32] & mask;
        keep_d = keep_n;
        wv_d   = 1'b1;
        idx_d  = idx_q + 5'd1;
      end else begin
        wv_d = 1'b0;
        if (state_q == DRAIN) begin
          p_d     = c_q;
          e_d     = e_q + EW'(64);
          state_d = HOLD;
        end else begin
          state_d = DONE;
        end
      end
    end
    if (state_q == DONE) begin
      e_d      = '0;
      p_held_d = 1'b0;
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      c_q      <= '0;
      p_held_q <= 1'b0;
      e_q      <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
      keep_q   <= '0;
      wv_q     <= 1'b0;
      idx_q    <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      c_q      <= c_d;
      p_held_q <= p_held_d;
      e_q      <= e_d;
      len_q    <= len_d;
      err_q    <= err_d;
      word_q   <= word_d;
      keep_q   <= keep_d;
      wv_q     <= wv_d;
      idx_q    <= idx_d;
      r_q      <= r_d;
    end
  end
endmodule

// File: tb/tb_sha_unpad.sv
// tb_sha_unpad: table-driven messages with a word scoreboard, plus stall and reset sequences.
module tb_sha_unpad;
  logic clk = 0, rst = 1;
  logic [511:0] block_i = '0;
  logic valid_i = 0, last_i = 0;
  logic accept_o, word_valid_o, word_ready_i, done_o, error_o;
  logic [31:0] word_o;
  logic [2:0] keep_o;
  logic [63:0] length_o;
  logic rdy_rand = 0, rnd_rdy = 1, rdy_man = 1;
  assign word_ready_i = rdy_rand ? rnd_rdy : rdy_man;
  always #5 clk = ~clk;
`ifdef SHA_UNPAD_CHECK_EN
  localparam bit CHK = 1;
`else
  localparam bit CHK = 0;
`endif
  sha_unpad #(.Nlen(64)) dut (
    .clk(clk), .rst(rst), .block_i(block_i), .valid_i(valid_i), .last_i(last_i),
    .accept_o(accept_o), .word_o(word_o), .keep_o(keep_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i), .done_o(done_o), .length_o(length_o), .error_o(error_o)
  );
  typedef struct {int nbytes; int mode; int exp_words; int exp_keep; bit err_chk; bit err_nochk;} vec_t;
  typedef struct {logic [31:0] w; logic [2:0] k;} exp_t;
  exp_t exp_q[$];
  exp_t e_pop;
  byte unsigned msg_q[$];
  byte unsigned pad_q[$];
  int n_pass = 0, n_total = 0, hs_cnt = 0, done_cnt = 0, msg_words = 0;
  logic [2:0] last_keep;
  bit sb_en = 1;
  logic [63:0] exp_len;
  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask
  always @(posedge clk) begin
    #1 rnd_rdy = $urandom_range(0, 3) != 0;
  end
  always @(negedge clk) begin
    if (!rst && word_valid_o && word_ready_i) begin
      hs_cnt++;
      msg_words++;
      last_keep = keep_o;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_extra_word: got %h, want no word", word_o);
        end else begin
          e_pop = exp_q.pop_front();
          check("sb_word", 64'(word_o), 64'(e_pop.w));
          check("sb_keep", 64'(keep_o), 64'(e_pop.k));
        end
      end
    end
    if (!rst && done_o) done_cnt++;
  end
  // mode: 0 good, 1 0x80 replaced by 0x00, 2 length not byte aligned, 3 length too large, 4 stray nonzero pad byte
  task automatic build_pad(int mode);
    int l = msg_q.size();
    logic [63:0] lenv;
    pad_q = msg_q;
    pad_q.push_back(mode == 1 ? 8'h00 : 8'h80);
    while (pad_q.size() % 64 != 56) pad_q.push_back(8'h00);
    if (mode == 4) pad_q[l+1] = 8'h5a;
    lenv = mode == 2 ? 64'(l*8 + 1) : mode == 3 ? 64'((l + 64)*8) : 64'(l*8);
    exp_len = lenv;
    for (int i = 7; i >= 0; i--) pad_q.push_back(lenv[i*8 +: 8]);
  endtask
  task automatic push_exp();
    int l = msg_q.size();
    exp_t e;
    for (int w = 0; w*4 < l; w++) begin
      e.w = '0;
      e.k = (l - 4*w >= 4) ? 3'd4 : 3'(l - 4*w);
      for (int j = 0; j < int'(e.k); j++) e.w[31-8*j -: 8] = msg_q[4*w + j];
      exp_q.push_back(e);
    end
  endtask
  task automatic send_blocks(int nmax);
    int nb = pad_q.size() / 64;
    int t;
    logic [511:0] blk;
    for (int b = 0; b < nb && b < nmax; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[(i/4)*32 + 24 - 8*(i%4) +: 8] = pad_q[b*64 + i];
      @(posedge clk);
      #1 block_i = blk; valid_i = 1; last_i = (b == nb - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!accept_o && t < 5000);
      check("accept_wait", 64'(t < 5000), 64'd1);
      @(posedge clk);
      #1 valid_i = 0; last_i = 0;
    end
  endtask
  task automatic wait_done();
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < 5000) begin @(negedge clk); t++; end
    check("done_pulses", 64'(done_cnt - start), 64'd1);
  endtask
  initial begin
    vec_t tv[14];
    bit ee;
    int h0, d0;
    logic [31:0] sw;
    logic [2:0] sk;
    tv = '{
      '{0,   0, 0,  0, 0, 0}, '{3,   0, 1,  3, 0, 0}, '{55,  0, 14, 3, 0, 0},
      '{56,  0, 14, 4, 0, 0}, '{64,  0, 16, 4, 0, 0}, '{119, 0, 30, 3, 0, 0},
      '{120, 0, 30, 4, 0, 0}, '{130, 0, 33, 2, 0, 0}, '{200, 0, 50, 4, 0, 0},
      '{3,   1, 1,  3, 1, 0}, '{20,  4, 5,  4, 1, 0}, '{3,   2, 0,  0, 1, 1},
      '{3,   3, 0,  0, 1, 1}, '{60,  3, 0,  0, 1, 1}
    };
    @(posedge clk);
    @(negedge clk);
    check("rst_accept", 64'(accept_o), 64'd1);
    check("rst_wvalid", 64'(word_valid_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_length", length_o, 64'd0);
    check("rst_word", 64'(word_o), 64'd0);
    check("rst_keep", 64'(keep_o), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    rdy_rand = 1;
    for (int v = 0; v < 14; v++) begin
      msg_q.delete();
      for (int j = 0; j < tv[v].nbytes; j++) msg_q.push_back(8'($urandom_range(0, 255)));
      build_pad(tv[v].mode);
      ee = CHK ? tv[v].err_chk : tv[v].err_nochk;
      if (!ee) push_exp();
      msg_words = 0;
      send_blocks(100);
      wait_done();
      check("vec_error", 64'(error_o), 64'(ee));
      check("vec_length", length_o, exp_len);
      check("vec_words", 64'(msg_words), ee ? 64'd0 : 64'(tv[v].exp_words));
      if (!ee && tv[v].exp_words > 0) check("vec_last_keep", 64'(last_keep), 64'(tv[v].exp_keep));
      check("vec_sb_left", 64'(exp_q.size()), 64'd0);
    end
    rdy_rand = 0;
    rdy_man = 1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    build_pad(0);
    exp_q.push_back('{32'h61626300, 3'd3});
    msg_words = 0;
    send_blocks(100);
    wait_done();
    check("abc_error", 64'(error_o), 64'd0);
    check("abc_length", length_o, 64'd24);
    check("abc_words", 64'(msg_words), 64'd1);
    check("abc_sb_left", 64'(exp_q.size()), 64'd0);
    msg_q.delete();
    for (int j = 0; j < 40; j++) msg_q.push_back(8'($urandom_range(0, 255)));
    build_pad(0);
    push_exp();
    msg_words = 0;
    h0 = hs_cnt;
    send_blocks(100);
    for (int t = 0; hs_cnt < h0 + 3 && t < 5000; t++) @(negedge clk);
    check("stall_reached", 64'(hs_cnt >= h0 + 3), 64'd1);
    @(posedge clk);
    #1 rdy_man = 0;
    @(negedge clk);
    sw = word_o;
    sk = keep_o;
    check("stall_wvalid", 64'(word_valid_o), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_word", 64'(word_o), 64'(sw));
      check("stall_keep", 64'(keep_o), 64'(sk));
      check("stall_wvalid_hold", 64'(word_valid_o), 64'd1);
    end
    @(posedge clk);
    #1 rdy_man = 1;
    wait_done();
    check("stall_words", 64'(msg_words), 64'd10);
    check("stall_error", 64'(error_o), 64'd0);
    check("stall_sb_left", 64'(exp_q.size()), 64'd0);
    sb_en = 0;
    msg_q.delete();
    for (int j = 0; j < 200; j++) msg_q.push_back(8'($urandom_range(0, 255)));
    build_pad(0);
    send_blocks(2);
    @(negedge clk);
    check("drain_accept_low", 64'(accept_o), 64'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    d0 = done_cnt;
    @(negedge clk);
    check("rst_mid_wvalid", 64'(word_valid_o), 64'd0);
    check("rst_mid_accept", 64'(accept_o), 64'd1);
    check("rst_mid_done", 64'(done_o), 64'd0);
    repeat (30) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    sb_en = 1;
    msg_q.delete();
    for (int j = 0; j < 10; j++) msg_q.push_back(8'($urandom_range(0, 255)));
    build_pad(0);
    push_exp();
    msg_words = 0;
    send_blocks(100);
    wait_done();
    check("recover_words", 64'(msg_words), 64'd3);
    check("recover_keep", 64'(last_keep), 64'd2);
    check("recover_length", length_o, 64'd80);
    check("recover_sb_left", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sha_unpad.md
SHA_UNPAD -- requirements
Module: sha_unpad

Interface
REQ-001 Parameter: Nlen, 64, width of the trailing message-length field in bits; only 64 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Block  in  512  padded block; word i at bits [i*32 +: 32]; first byte of each word in bits [31:24]; words 14:15 hold the message bit length (high:low).
REQ-005 Valid  in  1  Block (and Last) presented.
REQ-006 Last  in  1  the presented block is the final padded block.
REQ-007 Accept  out  1  block transfer occurs when Valid and Accept are both high.
REQ-008 Word  out  32  recovered message word, first byte in bits [31:24], unused low bytes zero.
REQ-009 Keep  out  3  valid bytes in Word, 1..4.
REQ-010 WordValid  out  1  Word/Keep valid.
REQ-011 WordReady  in  1  downstream accepts Word when WordValid and WordReady are both high.
REQ-012 Done  out  1  one-cycle pulse at end of message.
REQ-013 Length  out  64  latched message bit length; valid from the Done pulse until the next Last is accepted.
REQ-014 Error  out  1  malformed-message flag; valid with Done, held until the next Last is accepted.

Function
REQ-015 States: IDLE (no block held), HOLD (one block held in buffer P), DRAIN (emit P), CHECK (validate final), FINAL (emit tail), DONE.
REQ-016 Accept is high only in IDLE and HOLD.
REQ-017 Non-last block accepted in IDLE: store in P; go to HOLD.
REQ-018 Non-last block accepted in HOLD: store in buffer C; go to DRAIN; emit 16 words of P with Keep=4; then P<=C, emitted-byte counter E+=64; return to HOLD.
REQ-019 Last block accepted: store in C; latch Length from words 14:15; go to CHECK, which lasts one cycle.
REQ-020 CHECK: T=Length>>3; R=T-E; Error if Length[2:0]!=0; Error if P is held and R is not in 56..119; Error if P is not held and R>55.
REQ-021 CHECK padding test: byte at offset R of the P|C (or C-only) byte stream must be 0x80, and all bytes from R+1 up to byte 55 of C must be 0x00; any mismatch sets Error.
REQ-022 CHECK with Error: go to DONE; emit no words.
REQ-023 CHECK without Error: go to FINAL.
REQ-024 FINAL: emit ceil(R/4) words in stream order; Keep=4 on every word except the last, where Keep=R%4 (4 if R%4==0).
REQ-025 R=0: FINAL emits nothing and goes straight to DONE.
REQ-026 DONE: Done=1 for exactly one cycle; clear E and P-held; go to IDLE.
REQ-027 Output handshake: a word advances only when WordValid and WordReady are both high; Word and Keep are held stable while WordValid=1 and WordReady=0.
REQ-028 Word is registered; the first word appears at least one cycle after the state entry that produces it.
REQ-029 Valid while Accept=0 is ignored; the upstream block must stay presented.
REQ-030 E is (Nlen-3) bits wide and is not checked for wrap.

Reset
REQ-031 rst=1 at any clock edge: state=IDLE, P/C empty, E=0, Accept=1, WordValid=0, Done=0, Error=0, Length=0, Word=0, Keep=0.
REQ-032 Reset mid-DRAIN or mid-FINAL drops pending words; no Done is issued for the interrupted message.

Configuration
REQ-033 Macro SHA_UNPAD_CHECK_EN defined: the REQ-021 padding test is built in.
REQ-034 Macro SHA_UNPAD_CHECK_EN undefined: padding bytes are not inspected; Error comes only from the REQ-020 length checks; latency is unchanged.

Verification
REQ-035 "abc" single block (61 62 63 80 00.., Length=24, Last) -> one word 0x61626300, Keep=3; Done; Length=24; Error=0.
REQ-036 Empty message (0x80, zeros, Length=0, Last) -> no WordValid; Done; Error=0.
REQ-037 56-byte message padded to two blocks (Length=448, Last on the second) -> 14 words, Keep=4; Done; Error=0.
REQ-038 130-byte message in three blocks -> 32 words with Keep=4, then 0x????0000 with Keep=2; Accept low during DRAIN.
REQ-039 "abc" block with byte 3 set to 0x00 -> with SHA_UNPAD_CHECK_EN: no words, Done, Error=1; without it: one word, Error=0.
REQ-040 WordReady low for 5 cycles mid-FINAL -> Word and Keep stable, no loss; rst pulse mid-DRAIN -> WordValid=0 and Accept=1 the next cycle, no Done.
